// File: rtl/byte_nibble_tx_if.sv
// Byte-in / nibble-out handshake bundle for byte_nibble_tx.
interface byte_nibble_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_nib;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_nib, out_valid, out_last, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_nib, out_valid, out_last, busy
  );
endinterface

// File: rtl/byte_nibble_tx.sv
// Buffers bytes in a small FIFO and sends each as a pair of nibbles with a last marker.
// Optional BYTE_NIBBLE_TX_ZERO_SKIP_EN: bytes with a zero high nibble go out as one nibble.
module byte_nibble_tx #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned HIGH_FIRST = 0
) (
  input  logic           clk,
  input  logic           rst,
  byte_nibble_tx_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  state_t        state;
  logic [3:0]    hold_nib;
  logic [7:0]    head;
  logic          push;
  logic          pop;
  logic          skip;
  logic          out_done;
  logic          valid_nx;

  assign bus.in_ready = (count != CW'(DEPTH));
  assign head         = mem[rd_ptr];
  assign push         = bus.in_valid && bus.in_ready;
  assign out_done     = bus.out_valid && bus.out_ready;
  assign pop          = (count != '0) &&
                        ((state == IDLE) || ((state == SECOND) && out_done));

`ifdef BYTE_NIBBLE_TX_ZERO_SKIP_EN
  assign skip = (head[7:4] == 4'h0);
`else
  assign skip = 1'b0;
`endif

  // Next occupancy, also used to register busy without a cycle of lag
  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + CW'(1);
      2'b01:   count_nx = count - CW'(1);
      default: count_nx = count;
    endcase
  end

  assign valid_nx = pop || (bus.out_valid && !((state == SECOND) && out_done));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nx;
    end
  end

  // Output sequencer: a pop always starts a new byte, whatever the current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      hold_nib      <= 4'h0;
      bus.out_valid <= 1'b0;
      bus.out_nib   <= 4'h0;
      bus.out_last  <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.busy <= valid_nx || (count_nx != '0);
      if (pop) begin
        bus.out_valid <= 1'b1;
        if (skip) begin
          state        <= SECOND;
          bus.out_nib  <= head[3:0];
          bus.out_last <= 1'b1;
        end else begin
          state        <= FIRST;
          bus.out_last <= 1'b0;
          bus.out_nib  <= (HIGH_FIRST != 0) ? head[7:4] : head[3:0];
          hold_nib     <= (HIGH_FIRST != 0) ? head[3:0] : head[7:4];
        end
      end else if (out_done) begin
        case (state)
          FIRST: begin
            state        <= SECOND;
            bus.out_nib  <= hold_nib;
            bus.out_last <= 1'b1;
          end
          default: begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_byte_nibble_tx.sv
// Directed bench driving a low-first and a high-first instance with identical stimulus.
module tb_byte_nibble_tx;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  logic [4:0] q0[$];
  logic [4:0] q1[$];
  logic [4:0] e0[$];
  logic [4:0] e1[$];
  int         t0[$];

  logic       stall0 = 1'b0;
  logic       stall1 = 1'b0;
  logic [4:0] prev0  = '0;
  logic [4:0] prev1  = '0;

  logic [7:0] sb [6] = '{8'h81, 8'h92, 8'hB4, 8'hC5, 8'hD6, 8'hE7};
  logic [7:0] bb [3] = '{8'h12, 8'h34, 8'h56};
  logic [7:0] zb [3] = '{8'h07, 8'h00, 8'h17};

  byte_nibble_tx_if b0 ();
  byte_nibble_tx_if b1 ();

  assign b0.in_data   = in_data;
  assign b0.in_valid  = in_valid;
  assign b0.out_ready = out_ready;
  assign b1.in_data   = in_data;
  assign b1.in_valid  = in_valid;
  assign b1.out_ready = out_ready;

  byte_nibble_tx #(.DEPTH(2), .HIGH_FIRST(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  byte_nibble_tx #(.DEPTH(2), .HIGH_FIRST(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec = nvec + 1;
    if (got !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Collect accepted beats and confirm stalled outputs hold
  always @(negedge clk) begin
    if (rst) begin
      stall0 <= 1'b0;
      stall1 <= 1'b0;
    end else begin
      if (stall0) check("hold0", 32'({b0.out_last, b0.out_nib}), 32'(prev0));
      if (stall1) check("hold1", 32'({b1.out_last, b1.out_nib}), 32'(prev1));
      if (b0.out_valid && b0.out_ready) begin
        q0.push_back({b0.out_last, b0.out_nib});
        t0.push_back(cyc);
      end
      if (b1.out_valid && b1.out_ready) q1.push_back({b1.out_last, b1.out_nib});
      stall0 <= b0.out_valid && !b0.out_ready;
      stall1 <= b1.out_valid && !b1.out_ready;
      prev0  <= {b0.out_last, b0.out_nib};
      prev1  <= {b1.out_last, b1.out_nib};
    end
  end

  function automatic void add_exp(input logic [7:0] b);
    bit sk;
`ifdef BYTE_NIBBLE_TX_ZERO_SKIP_EN
    sk = (b[7:4] == 4'h0);
`else
    sk = 1'b0;
`endif
    if (sk) begin
      e0.push_back({1'b1, b[3:0]});
      e1.push_back({1'b1, b[3:0]});
    end else begin
      e0.push_back({1'b0, b[3:0]});
      e0.push_back({1'b1, b[7:4]});
      e1.push_back({1'b0, b[7:4]});
      e1.push_back({1'b1, b[3:0]});
    end
  endfunction

  task automatic verify(input string tag);
    check({tag, "_n0"}, 32'(q0.size()), 32'(e0.size()));
    check({tag, "_n1"}, 32'(q1.size()), 32'(e1.size()));
    foreach (e0[i]) if (i < q0.size()) check({tag, "_b0"}, 32'(q0[i]), 32'(e0[i]));
    foreach (e1[i]) if (i < q1.size()) check({tag, "_b1"}, 32'(q1[i]), 32'(e1[i]));
    q0.delete();
    q1.delete();
    e0.delete();
    e1.delete();
    t0.delete();
  endtask

  task automatic drain(input string tag, input bit rnd);
    for (int i = 0; i < 200; i++) begin
      if (!b0.busy && !b1.busy) break;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick;
    end
    out_ready = 1'b1;
    check({tag, "_drain"}, 32'(b0.busy | b1.busy), 32'd0);
  endtask

  task automatic push(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    tick;
    tick;
    check("rst_valid", 32'(b0.out_valid | b1.out_valid), 32'd0);
    check("rst_busy",  32'(b0.busy | b1.busy), 32'd0);
    check("rst_rdy",   32'(b0.in_ready & b1.in_ready), 32'd1);
    check("rst_nib",   32'({b0.out_last, b0.out_nib}), 32'd0);
    rst = 1'b0;
    tick;
    tick;
    check("idle_valid", 32'(b0.out_valid), 32'd0);
    check("idle_busy",  32'(b0.busy), 32'd0);
    check("idle_rdy",   32'(b0.in_ready), 32'd1);

    // Single byte: latency and nibble order for both orientations
    push(8'hA5);
    check("a5_lat",  32'(b0.out_valid), 32'd0);
    check("a5_busy", 32'(b0.busy), 32'd1);
    tick;
    check("a5_v1", 32'(b0.out_valid & b1.out_valid), 32'd1);
    check("a5_n1_lo", 32'({b0.out_last, b0.out_nib}), 32'h05);
    check("a5_n1_hi", 32'({b1.out_last, b1.out_nib}), 32'h0A);
    tick;
    check("a5_n2_lo", 32'({b0.out_last, b0.out_nib}), 32'h1A);
    check("a5_n2_hi", 32'({b1.out_last, b1.out_nib}), 32'h15);
    tick;
    check("a5_done", 32'(b0.out_valid | b0.busy), 32'd0);
    add_exp(8'hA5);
    verify("a5");

    // Back-to-back bytes stream with no bubbles
    for (int i = 0; i < 3; i++) begin
      push(bb[i]);
      add_exp(bb[i]);
    end
    drain("b2b", 1'b0);
    for (int i = 1; i < t0.size(); i++) check("b2b_gap", 32'(t0[i] - t0[i-1]), 32'd1);
    verify("b2b");

    // Stall until full, then release
    out_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (!b0.in_ready) break;
      push(sb[i]);
      n++;
    end
    check("stall_cnt", 32'(n), 32'd3);
    check("stall_rdy", 32'(b0.in_ready | b1.in_ready), 32'd0);
    repeat (4) tick;
    check("stall_lo", 32'({b0.out_valid, b0.out_last, b0.out_nib}), 32'h21);
    check("stall_hi", 32'({b1.out_valid, b1.out_last, b1.out_nib}), 32'h28);
    for (int i = 0; i < 3; i++) add_exp(sb[i]);
    out_ready = 1'b1;
    drain("stall", 1'b0);
    verify("stall");

    // Random backpressure on one byte
    out_ready = 1'($urandom_range(0, 1));
    push(8'hC3);
    drain("rnd", 1'b1);
    add_exp(8'hC3);
    verify("rnd");

    // Reset in the middle of a byte with the FIFO occupied
    out_ready = 1'b0;
    push(8'hA5);
    push(8'h3C);
    tick;
    check("mid_pre", 32'(b0.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_valid", 32'(b0.out_valid | b1.out_valid), 32'd0);
    check("mid_out",   32'({b0.out_last, b0.out_nib}), 32'd0);
    check("mid_busy",  32'(b0.busy | b1.busy), 32'd0);
    check("mid_rdy",   32'(b0.in_ready & b1.in_ready), 32'd1);
    tick;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick;
    check("mid_after", 32'(b0.out_valid | b0.busy), 32'd0);
    verify("mid");

    // Bytes with a zero high nibble
    for (int i = 0; i < 3; i++) begin
      push(zb[i]);
      add_exp(zb[i]);
    end
    drain("zero", 1'b0);
    verify("zero");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/byte_nibble_tx.md
Name: byte_nibble_tx

Overview:
- Narrowing counterpart of the CPU's 4-bit to 8-bit zero-extension path.
- Accepts 8-bit bytes on a valid/ready input and transmits each byte as a stream of 4-bit nibbles on a valid/ready output, with a last-nibble marker.
- Sits between the 8-bit datapath and 4-bit consumers (nibble bus, display, debug port).
- A small byte FIFO decouples the producer from output stalls.

Parameters:
- DEPTH, 2, byte FIFO entries; power of 2, at least 2.
- HIGH_FIRST, 0, 0 = low nibble sent first; 1 = high nibble sent first.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_data  input  8  byte to transmit
- in_valid  input  1  in_data valid
- in_ready  output  1  FIFO can accept a byte; equals !full (combinational from registered count)
- out_nib  output  4  current nibble
- out_valid  output  1  out_nib valid
- out_ready  input  1  consumer accepts nibble
- out_last  output  1  out_nib is the final nibble of its byte
- busy  output  1  out_valid OR FIFO non-empty

Behaviour:
- Reset (async, active-high): FIFO pointers and count = 0; state = IDLE; out_valid = 0, out_nib = 0, out_last = 0, busy = 0. in_ready = 1 while in reset and immediately after.
- Push: occurs on an edge where in_valid && in_ready. No push when full, even if a pop happens in the same cycle.
- Pop: loads the FIFO head into the output holding register; occurs only on the state transitions marked (pop) below.
- Push and pop in the same cycle are legal when count is strictly between 0 and DEPTH; count is unchanged.
- Count width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Output state machine:
  - IDLE: out_valid = 0. If count != 0, go to FIRST (pop).
  - FIRST: out_valid = 1, out_last = 0. out_nib = byte[3:0] (HIGH_FIRST = 0) or byte[7:4] (HIGH_FIRST = 1). On out_valid && out_ready, go to SECOND.
  - SECOND: out_valid = 1, out_last = 1, out_nib = the other nibble. On handshake: if count != 0, go to FIRST (pop); else go to IDLE.
- Latency: a byte pushed at edge k into an empty, idle block gives out_valid = 1 after edge k+1. Sustained throughput is one nibble per cycle (two cycles per byte).
- Stability: while out_valid && !out_ready, out_nib and out_last hold steady. A byte is never dropped or duplicated.
- Ordering: bytes leave in arrival order; nibble order within a byte follows HIGH_FIRST.
- Narrowing is lossless: all 8 bits always appear across the nibbles of a byte. No arithmetic on data.
- Reset mid-byte: any partially sent byte and all FIFO contents are discarded. Outputs return to reset values asynchronously.
- out_ready held low indefinitely: FIFO fills, in_ready drops to 0, nothing is lost.

Optional Feature:
- Macro: BYTE_NIBBLE_TX_ZERO_SKIP_EN.
- Defined: when a popped byte has byte[7:4] == 4'h0, the state machine enters SECOND directly, presenting byte[3:0] with out_last = 1. One beat is sent, inverting zero-extension. This applies regardless of HIGH_FIRST.
- Byte 8'h00 transmits as a single nibble 4'h0 with out_last = 1.
- Undefined: every byte always sends two nibbles; no zero check is synthesised.

Test Plan:
- Reset, then idle -> out_valid = 0, busy = 0, in_ready = 1. Assert rst mid-transfer -> outputs clear immediately, in_ready = 1.
- HIGH_FIRST = 0, push 8'hA5, out_ready = 1 -> out_nib 4'h5 (last = 0), then 4'hA (last = 1) on consecutive cycles, out_valid rising one cycle after the push edge. With HIGH_FIRST = 1 -> 4'hA then 4'h5.
- Back-to-back push of 8'h12, 8'h34, 8'h56 with out_ready = 1 -> continuous nibbles 2,1,4,3,6,5, out_last on every second beat, no bubble.
- out_ready = 0, push until in_ready = 0 (DEPTH bytes plus the one in the holding register), then release -> all bytes emerge in order with none lost. Hold out_nib stable during the stall.
- Toggle out_ready randomly with 8'hC3 in flight -> each nibble is accepted exactly once; out_nib and out_last are unchanged while stalled.
- With BYTE_NIBBLE_TX_ZERO_SKIP_EN, push 8'h07, then 8'h00, then 8'h17 -> 4'h7 (last), 4'h0 (last), then 4'h7 and 4'h1 (last). Without the macro, 8'h07 -> 4'h7 then 4'h0 (last).
